// File: rtl/pe_spad_loader.sv
// PE scratchpad loader: steers depacketized words into per-row filter/ifmap
// scratchpads and hands complete timesteps to the MAC datapath.
module pe_spad_loader #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ROW_BITS   = 2,
  parameter int unsigned NUM_ROWS   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ROW_BITS-1:0]   in_row,
  input  logic                  in_ifmapb_filter,
  input  logic                  in_timestep,
  input  logic [ROW_BITS-1:0]   rd_row,
  output logic [DATA_WIDTH-1:0] filt_rdata,
  output logic [DATA_WIDTH-1:0] ifmap_rdata,
  output logic                  start,
  input  logic                  pe_done,
  output logic                  busy,
  output logic                  cur_timestep,
  output logic                  err
);

  localparam int unsigned      CMP_W     = ROW_BITS + 1;
  localparam logic [CMP_W-1:0] ROW_LIMIT = CMP_W'(NUM_ROWS);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  state_t                state;
  logic [NUM_ROWS-1:0]   filt_loaded;
  logic [NUM_ROWS-1:0]   ifmap_loaded;
  logic [DATA_WIDTH-1:0] filt_mem  [NUM_ROWS];
  logic [DATA_WIDTH-1:0] ifmap_mem [NUM_ROWS];

  logic                  beat;
  logic                  row_ok;
  logic                  filt_wr;
  logic                  ifmap_wr;
  logic                  drop;
  logic [NUM_ROWS-1:0]   filt_set;
  logic [NUM_ROWS-1:0]   ifmap_set;
  logic [NUM_ROWS-1:0]   filt_next;
  logic [NUM_ROWS-1:0]   ifmap_next;
  logic                  all_loaded;

  // Beat classification; in_ready is only high in LOAD so writes never land in START/BUSY.
  assign beat       = in_valid & in_ready;
  assign row_ok     = {1'b0, in_row} < ROW_LIMIT;
  assign filt_wr    = beat & in_ifmapb_filter & row_ok;
  assign ifmap_wr   = beat & ~in_ifmapb_filter & row_ok & (in_timestep == cur_timestep);
  assign drop       = beat & ~(filt_wr | ifmap_wr);
  assign filt_set   = filt_wr  ? (NUM_ROWS'(1) << in_row) : '0;
  assign ifmap_set  = ifmap_wr ? (NUM_ROWS'(1) << in_row) : '0;
  assign filt_next  = filt_loaded | filt_set;
  assign ifmap_next = ifmap_loaded | ifmap_set;
  assign all_loaded = (&filt_next) & (&ifmap_next);

  // Scratchpad storage, contents need no reset.
  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (filt_set[r])  filt_mem[r]  <= in_data;
      if (ifmap_set[r]) ifmap_mem[r] <= in_data;
    end
  end

  // Datapath read ports; rows beyond NUM_ROWS read as zero.
  always_comb begin
    filt_rdata  = '0;
    ifmap_rdata = '0;
    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
      if (rd_row == ROW_BITS'(r)) begin
        filt_rdata  = filt_mem[r];
        ifmap_rdata = ifmap_mem[r];
      end
    end
  end

  // Control FSM with registered handshake/status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_LOAD;
      filt_loaded  <= '0;
      ifmap_loaded <= '0;
      cur_timestep <= 1'b0;
      err          <= 1'b0;
      start        <= 1'b0;
      busy         <= 1'b0;
      in_ready     <= 1'b1;
    end else begin
      case (state)
        ST_LOAD: begin
          filt_loaded  <= filt_next;
          ifmap_loaded <= ifmap_next;
          if (drop) err <= 1'b1;
          if (all_loaded) begin
            state    <= ST_START;
            start    <= 1'b1;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        ST_START: begin
          state <= ST_BUSY;
          start <= 1'b0;
        end
        ST_BUSY: begin
          // Filters persist across timesteps; only ifmap rows reload.
          if (pe_done) begin
            state        <= ST_LOAD;
            ifmap_loaded <= '0;
            cur_timestep <= ~cur_timestep;
            busy         <= 1'b0;
            in_ready     <= 1'b1;
          end
        end
        default: begin
          state    <= ST_LOAD;
          start    <= 1'b0;
          busy     <= 1'b0;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_spad_loader.sv
// Directed bench for pe_spad_loader with a reference model and a scoreboard of
// expected scratchpad snapshots popped when the DUT starts its datapath.
module tb_pe_spad_loader;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_data;
  logic [1:0]  in_row;
  logic        in_ifmapb_filter;
  logic        in_timestep;
  logic [1:0]  rd_row;
  logic [23:0] filt_rdata;
  logic [23:0] ifmap_rdata;
  logic        start;
  logic        pe_done;
  logic        busy;
  logic        cur_timestep;
  logic        err;

  pe_spad_loader #(.DATA_WIDTH(24), .ROW_BITS(2), .NUM_ROWS(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_row           (in_row),
    .in_ifmapb_filter (in_ifmapb_filter),
    .in_timestep      (in_timestep),
    .rd_row           (rd_row),
    .filt_rdata       (filt_rdata),
    .ifmap_rdata      (ifmap_rdata),
    .start            (start),
    .pe_done          (pe_done),
    .busy             (busy),
    .cur_timestep     (cur_timestep),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][23:0] f;
    logic [2:0][23:0] i;
  } snap_t;

  snap_t       sb[$];
  logic [23:0] mf [4];
  logic [23:0] mi [4];
  logic [3:0]  mfl;
  logic [3:0]  mil;
  logic        mts;
  logic        merr;
  int          errors;
  int          checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of one accepted beat; pushes a snapshot when both pads fill.
  task automatic model_beat(input logic f, input logic [1:0] row, input logic ts,
                            input logic [23:0] d, output logic exp_start);
    snap_t s;
    if (row < 2'd3 && f) begin
      mf[row] = d; mfl[row] = 1'b1;
    end else if (row < 2'd3 && !f && ts == mts) begin
      mi[row] = d; mil[row] = 1'b1;
    end else begin
      merr = 1'b1;
    end
    exp_start = (&mfl[2:0]) && (&mil[2:0]);
    if (exp_start) begin
      for (int r = 0; r < 3; r++) begin
        s.f[r] = mf[r];
        s.i[r] = mi[r];
      end
      sb.push_back(s);
    end
  endtask

  task automatic send(input string tag, input logic f, input logic [1:0] row,
                      input logic ts, input logic [23:0] d);
    logic es;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_ifmapb_filter = f; in_row = row; in_timestep = ts; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_beat(f, row, ts, d, es);
    chk({tag, "_start"}, 32'(start), 32'(es));
    chk({tag, "_err"},   32'(err),   32'(merr));
  endtask

  // Called in the START cycle: step into BUSY and compare pads against the snapshot.
  task automatic busy_phase(input string tag);
    snap_t s;
    @(posedge clk); #1;
    chk({tag, "_start_lo"}, 32'(start),    32'd0);
    chk({tag, "_busy"},     32'(busy),     32'd1);
    chk({tag, "_rdy_lo"},   32'(in_ready), 32'd0);
    chk({tag, "_sb_depth"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      s = sb.pop_front();
      for (int r = 0; r < 3; r++) begin
        rd_row = 2'(r); #1;
        chk({tag, "_filt_rd"},  32'(filt_rdata),  32'(s.f[r]));
        chk({tag, "_ifmap_rd"}, 32'(ifmap_rdata), 32'(s.i[r]));
      end
    end
    rd_row = 2'd3; #1;
    chk({tag, "_filt_oob"},  32'(filt_rdata),  32'd0);
    chk({tag, "_ifmap_oob"}, 32'(ifmap_rdata), 32'd0);
    rd_row = 2'd0;
  endtask

  task automatic finish_ts(input string tag);
    pe_done = 1'b1;
    @(posedge clk); #1;
    pe_done = 1'b0;
    mil = '0;
    mts = ~mts;
    chk({tag, "_rdy"},  32'(in_ready),     32'd1);
    chk({tag, "_busy"}, 32'(busy),         32'd0);
    chk({tag, "_ts"},   32'(cur_timestep), 32'(mts));
  endtask

  initial begin
    logic es;
    errors = 0; checks = 0;
    mfl = '0; mil = '0; mts = 1'b0; merr = 1'b0;
    for (int r = 0; r < 4; r++) begin mf[r] = '0; mi[r] = '0; end
    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_row = '0;
    in_ifmapb_filter = 1'b0; in_timestep = 1'b0; rd_row = '0; pe_done = 1'b0;
    #1;
    chk("rst_rdy",   32'(in_ready),     32'd1);
    chk("rst_busy",  32'(busy),         32'd0);
    chk("rst_start", 32'(start),        32'd0);
    chk("rst_err",   32'(err),          32'd0);
    chk("rst_ts",    32'(cur_timestep), 32'd0);
    #11 reset = 1'b0;
    @(posedge clk); #1;

    // Full load at timestep 0
    for (int r = 0; r < 3; r++) send("full_f", 1'b1, 2'(r), 1'b0, 24'hA00000 + 24'(r));
    for (int r = 0; r < 3; r++) send("full_i", 1'b0, 2'(r), 1'b0, 24'h100000 + 24'(r));
    busy_phase("full");
    rd_row = 2'd1; #1;
    chk("full_f1", 32'(filt_rdata),  32'hA00001);
    chk("full_i1", 32'(ifmap_rdata), 32'h100001);
    rd_row = 2'd0;
    finish_ts("adv1");

    // Overwrite and out-of-order ifmap rows at timestep 1
    send("ovw_r2a", 1'b0, 2'd2, 1'b1, 24'h000001);
    send("ovw_r2b", 1'b0, 2'd2, 1'b1, 24'h000002);
    send("ovw_r1",  1'b0, 2'd1, 1'b1, 24'h000003);
    send("ovw_r0",  1'b0, 2'd0, 1'b1, 24'h000004);
    busy_phase("ovw");
    rd_row = 2'd2; #1;
    chk("ovw_i2", 32'(ifmap_rdata), 32'h000002);
    rd_row = 2'd0;
    finish_ts("adv2");

    // Dropped beats at timestep 0
    send("drop_row", 1'b1, 2'd3, 1'b0, 24'hDEAD00);
    send("drop_ts",  1'b0, 2'd0, 1'b1, 24'hDEAD01);
    for (int r = 0; r < 3; r++) begin
      rd_row = 2'(r); #1;
      chk("drop_filt_keep", 32'(filt_rdata), 32'(mf[r]));
    end
    rd_row = 2'd0;

    // Ifmap-only reload reuses the stored filters
    for (int r = 0; r < 3; r++) send("reload_i", 1'b0, 2'(r), 1'b0, 24'h200000 + 24'(r));
    busy_phase("reload");

    // Backpressure: bundle held during BUSY is taken only after pe_done
    in_valid = 1'b1; in_ifmapb_filter = 1'b0; in_row = 2'd0; in_timestep = 1'b1;
    in_data = 24'h000055;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("bp_rdy",  32'(in_ready),    32'd0);
      chk("bp_data", 32'(ifmap_rdata), 32'(mi[0]));
    end
    finish_ts("bp_done");
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_beat(1'b0, 2'd0, 1'b1, 24'h000055, es);
    chk("bp_start", 32'(start),       32'(es));
    chk("bp_acc",   32'(ifmap_rdata), 32'h000055);
    chk("bp_err",   32'(err),         32'(merr));

    // Async reset while BUSY
    send("pre_rst_r1", 1'b0, 2'd1, 1'b1, 24'h300001);
    send("pre_rst_r2", 1'b0, 2'd2, 1'b1, 24'h300002);
    busy_phase("pre_rst");
    #1 reset = 1'b1;
    #1;
    chk("arst_rdy",   32'(in_ready),     32'd1);
    chk("arst_busy",  32'(busy),         32'd0);
    chk("arst_start", 32'(start),        32'd0);
    chk("arst_err",   32'(err),          32'd0);
    chk("arst_ts",    32'(cur_timestep), 32'd0);
    chk("sb_drained", 32'(sb.size()),    32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
